// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the pipeline and the multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        mthiEn;
    logic        mtloEn;
    logic [31:0] mtData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rsData, rtData, mthiEn, mtloEn, mtData,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rsData, rtData, mthiEn, mtloEn, mtData,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (32 cycles per op) with HI/LO registers.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mul_div_unit (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opb_reg;
    logic        neg_reg;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        accept, last_iter, signed_op, move_ok;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] prod_fixed;

`ifdef MDU_DIV_EN
    logic        div_reg, neg_r_reg, div_zero_reg;
    logic [32:0] div_shift, div_diff;
    logic [31:0] quo_fixed, rem_fixed;

    assign accept = bus.start;
`else
    assign accept = bus.start & ~bus.op[1];
`endif

    assign signed_op = ~bus.op[0];
    assign mag_a     = (signed_op && bus.rsData[31]) ? -bus.rsData : bus.rsData;
    assign mag_b     = (signed_op && bus.rtData[31]) ? -bus.rtData : bus.rtData;
    assign last_iter = (state_reg == RUN) && (count_reg == 5'd31);
    assign move_ok   = (state_reg != RUN) && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (count_reg == 5'd31) state_next = DONE;
            default: state_next = accept ? RUN : IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg == RUN);
        bus.done = (state_reg == DONE);
    end

    assign bus.hi = hi_reg;
    assign bus.lo = lo_reg;

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right each step.
    assign mul_sum = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opb_reg : 32'd0)};

`ifdef MDU_DIV_EN
    // Divide: acc = {remainder, dividend/quotient}, shift left and trial-subtract.
    assign div_shift = acc_reg[63:31];
    assign div_diff  = div_shift - {1'b0, opb_reg};

    always_comb begin
        if (div_reg) begin
            acc_next = div_diff[32] ? {div_shift[31:0], acc_reg[30:0], 1'b0}
                                    : {div_diff[31:0], acc_reg[30:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc_reg[31:1]};
        end
    end

    assign quo_fixed = div_zero_reg ? 32'hFFFF_FFFF
                                    : (neg_reg ? -acc_next[31:0] : acc_next[31:0]);
    assign rem_fixed = neg_r_reg ? -acc_next[63:32] : acc_next[63:32];
`else
    assign acc_next = {mul_sum, acc_reg[31:1]};
`endif

    assign prod_fixed = neg_reg ? -acc_next : acc_next;

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (last_iter) begin
`ifdef MDU_DIV_EN
            if (div_reg) begin
                hi_next = rem_fixed;
                lo_next = quo_fixed;
            end else begin
                hi_next = prod_fixed[63:32];
                lo_next = prod_fixed[31:0];
            end
`else
            hi_next = prod_fixed[63:32];
            lo_next = prod_fixed[31:0];
`endif
        end else if (move_ok) begin
            if (bus.mthiEn) hi_next = bus.mtData;
            if (bus.mtloEn) lo_next = bus.mtData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 5'd0;
            acc_reg      <= 64'd0;
            opb_reg      <= 32'd0;
            neg_reg      <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
`ifdef MDU_DIV_EN
            div_reg      <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
`endif
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
            if ((state_reg != RUN) && accept) begin
                count_reg <= 5'd0;
                neg_reg   <= signed_op & (bus.rsData[31] ^ bus.rtData[31]);
`ifdef MDU_DIV_EN
                div_reg      <= bus.op[1];
                neg_r_reg    <= signed_op & bus.rsData[31];
                div_zero_reg <= (bus.rtData == 32'd0);
                acc_reg      <= bus.op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
                opb_reg      <= bus.op[1] ? mag_b : mag_a;
`else
                acc_reg      <= {32'd0, mag_b};
                opb_reg      <= mag_a;
`endif
            end else if (state_reg == RUN) begin
                count_reg <= count_reg + 5'd1;
                acc_reg   <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against a plain-arithmetic model.
// Divide cases run only when MDU_DIV_EN is defined; otherwise divide ops must be ignored.
`timescale 1ns/1ps
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n;

    mul_div_unit_if bus ();
    mul_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi, model_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              q, r;
        case (o)
            2'd0: begin
                sp = longint'(signed'(a)) * longint'(signed'(b));
                return 64'(sp);
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return 64'(up);
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = signed'(a) / signed'(b);
                r = signed'(a) % signed'(b);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hilo", {bus.hi, bus.lo}, e);
                end
            end
        end
    end

    // Issue one op at the current negedge; optional interference at iteration `inject`.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input bit mt_same);
        logic [63:0] e;
        int          lat;
        bit          fin;
        e = ref_model(o, a, b);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rsData = a;
        bus.rtData = b;
        bus.mthiEn = mt_same;
        bus.mtloEn = mt_same;
        bus.mtData = 32'h0000_1234;
        exp_q.push_back(e);
        lat = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            bus.start  = 1'b0;
            bus.mthiEn = 1'b0;
            bus.mtloEn = 1'b0;
            if (bus.done === 1'b1) begin
                fin = 1'b1;
            end else begin
                lat++;
                check("busy_in_run", 64'(bus.busy), 64'd1);
                if (lat == 1 || lat == 32)
                    check("hilo_held_in_run", {bus.hi, bus.lo}, {model_hi, model_lo});
                if (lat == inject) begin
                    bus.start  = 1'b1;
                    bus.op     = 2'($urandom_range(0, 3));
                    bus.rsData = 32'($urandom);
                    bus.rtData = 32'($urandom);
                    bus.mthiEn = 1'b1;
                    bus.mtloEn = 1'b1;
                    bus.mtData = 32'h0000_DEAD;
                end
                if (lat > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL done_timeout: got no done after %0d cycles expected 32", lat);
                    exp_q.delete();
                    fin = 1'b1;
                end
            end
        end
        check("latency", 64'(lat), 64'd32);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] d);
        bus.mthiEn = h;
        bus.mtloEn = l;
        bus.mtData = d;
        @(negedge clk);
        bus.mthiEn = 1'b0;
        bus.mtloEn = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
        check("mt_move", {bus.hi, bus.lo}, {model_hi, model_lo});
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          bad;
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.rsData = 32'd0;
        bus.rtData = 32'd0;
        bus.mthiEn = 1'b0;
        bus.mtloEn = 1'b0;
        bus.mtData = 32'd0;
        model_hi   = 32'd0;
        model_lo   = 32'd0;
        rst_n      = 1'b0;
        #3;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        check("multu_hi_const", 64'(bus.hi), 64'h1);
        check("multu_lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
        check("mult_lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
        mt(1'b1, 1'b0, 32'hCAFE_0001);
        mt(1'b0, 1'b1, 32'hCAFE_0002);
        mt(1'b1, 1'b1, 32'h1357_9BDF);
        run_op(2'd1, 32'd5, 32'd6, 10, 1'b0);
        check("ignored_start_lo", 64'(bus.lo), 64'd30);
        run_op(2'd1, 32'd5, 32'd5, 0, 1'b1);

`ifdef MDU_DIV_EN
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        run_op(2'd3, 32'd100, 32'd0, 0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
`else
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            bus.start  = (i < 39);
            bus.op     = (i < 20) ? 2'd2 : 2'd3;
            bus.rsData = 32'd9;
            bus.rtData = 32'd3;
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        bus.start = 1'b0;
        check("div_ignored_busy_done", 64'(bad), 64'd0);
        check("div_ignored_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
`endif

        for (int n = 0; n < 24; n++) begin
            o = DIV_EN ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op(o, a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
        end

        // Abort a run with reset midway; hi/lo must clear without a clock edge.
        mt(1'b1, 1'b1, 32'h5A5A_A5A5);
        bus.start  = 1'b1;
        bus.op     = DIV_EN ? 2'd3 : 2'd1;
        bus.rsData = 32'd1000;
        bus.rtData = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'd1, 32'd2, 32'd3, 0, 1'b0);
        check("after_abort_lo", 64'(bus.lo), 64'd6);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 ns expected earlier finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; operand and result width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin the operation selected by op, using rsData/rtData.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rsData  input  32  operand A: multiplicand or dividend, taken from register-file readData1.
REQ-007 rtData  input  32  operand B: multiplier or divisor, taken from register-file readData2.
REQ-008 mthiEn  input  1  load hi from mtData.
REQ-009 mtloEn  input  1  load lo from mtData.
REQ-010 mtData  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse; hi/lo hold the new result.
REQ-013 hi  output  32  HI register, feeding the register-file writeData mux for MFHI.
REQ-014 lo  output  32  LO register, feeding the register-file writeData mux for MFLO.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 Transitions:
- IDLE or DONE with start=1: go to RUN, capture operands and op, set the iteration counter to 0.
- IDLE or DONE with start=0: go to IDLE.
- RUN: stay in RUN until the 32nd iteration edge, then go to DONE.
REQ-017 RUN SHALL perform one iteration per cycle: shift-add for multiply, restoring subtract-shift for divide. Exactly 32 iterations SHALL be performed, counter 0..31.
REQ-018 Signed ops (MULT, DIV) SHALL operate on operand magnitudes.
- Sign correction SHALL be applied on the final iteration edge.
- Quotient sign = sign(A) XOR sign(B).
- Remainder sign = sign(A).
REQ-019 Multiply SHALL write hi = product[63:32] and lo = product[31:0]. Divide SHALL write lo = quotient and hi = remainder.
REQ-020 hi/lo SHALL be written on the edge that enters DONE. If start is sampled at edge N, results are visible and done=1 in the cycle after edge N+32.
REQ-021 busy SHALL be 1 exactly while in RUN. done SHALL be 1 exactly while in DONE.
REQ-022 start sampled while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-023 Divide by zero SHALL take the full 32 cycles and then write lo = 32'hFFFFFFFF, hi = rsData.
REQ-024 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write lo = 32'h80000000, hi = 0.
REQ-025 mthiEn/mtloEn in IDLE or DONE SHALL load hi/lo from mtData on the next edge. Both may be asserted together.
REQ-026 mthiEn/mtloEn while in RUN SHALL be ignored.
REQ-027 If start and mthiEn/mtloEn are asserted in the same cycle, start SHALL win and the move SHALL be ignored.
REQ-028 hi/lo SHALL hold their value in all cases not covered above.

Reset
REQ-029 While rst_n=0, the block SHALL immediately hold:
- state = IDLE
- busy = 0, done = 0
- hi = 0, lo = 0
- iteration counter = 0
REQ-030 Reset asserted during RUN SHALL abort the operation, with no partial result left in hi/lo.
REQ-031 The first operation SHALL be accepted on the first posedge clk after rst_n rises.

Configuration
REQ-032 Macro MDU_DIV_EN SHALL control divide support.
- Defined: DIV and DIVU SHALL behave per REQ-017..REQ-024.
- Undefined: the divide datapath SHALL be absent. start with op[1]=1 SHALL be ignored: state stays IDLE, busy/done stay 0, hi/lo unchanged. Multiply behaviour SHALL be identical in both builds.

Verification
REQ-033 MULTU: rsData=32'hFFFFFFFF, rtData=32'h00000002, start at edge N -> busy for 32 cycles; done after edge N+32 with hi=32'h00000001, lo=32'hFFFFFFFE.
REQ-034 MULT: rsData=-3, rtData=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB (-21).
REQ-035 DIV: rsData=-7, rtData=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU: rsData=100, rtData=0 -> lo=32'hFFFFFFFF, hi=100.
REQ-036 Start MULTU 5x6, pulse start again with new operands and mthiEn=1, mtData=32'hDEAD at iteration 10 -> both ignored; done gives hi=0, lo=30.
REQ-037 Start DIVU, drop rst_n at iteration 15 -> busy=0, hi=lo=0 at once without a clock edge; a new MULTU 2x3 after release -> lo=6.
REQ-038 Build without MDU_DIV_EN, start with op=10 -> busy and done stay 0 for 40 cycles and hi/lo are unchanged.
